// File: rtl/d_mem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Also provides the synchronous active-low DFF macro used by the d_mem blocks.
`ifndef D_MEM_DFF_RN
`define D_MEM_DFF_RN(clk, rst_n, q, d, rv) \
    always_ff @(posedge clk) begin \
        if (!(rst_n)) q <= (rv); \
        else q <= (d); \
    end
`endif

package d_mem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } d_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
        ST_P2   = 2'd2,
`endif
        ST_DONE = 2'd3
    } d_state_e;

    // LSB-aligned byte-enable mask for an access size
    function automatic logic [3:0] size_mask(input d_size_e size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    // Access spills past the end of its aligned word
    function automatic logic is_crossing(input d_size_e size, input logic [1:0] offset);
        is_crossing = ((size == SZ_HALF) && (offset == 2'd3)) ||
                      ((size == SZ_WORD) && (offset != 2'd0));
    endfunction

endpackage

// File: rtl/d_mem_ld_ext.sv
// Load-data merge of the two word halves of a split access, then sign/zero extension.
// Merge inputs exist only when D_MEM_LSU_MISALIGN_SPLIT_EN is defined.
module d_mem_ld_ext
    import d_mem_pkg::*;
(
`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
    input  logic [WORD_W-1:0] part_a,
    input  logic [1:0]        offset,
    input  logic              merge,
`endif
    input  logic [WORD_W-1:0] rd_data,
    input  d_size_e           size,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] data_c
);

    logic [WORD_W-1:0] raw;

`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
    logic [1:0] lo_bytes;
    logic [4:0] shamt;

    // Second-word bytes land above the 4-offset bytes captured in the first access
    always_comb begin
        lo_bytes = 2'(3'd4 - {1'b0, offset});
        shamt    = {lo_bytes, 3'b000};
        raw      = merge ? (part_a | (rd_data << shamt)) : rd_data;
    end
`else
    assign raw = rd_data;
`endif

    always_comb begin
        data_c = raw;
        case (size)
            SZ_BYTE: data_c = is_unsigned ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
            SZ_HALF: data_c = is_unsigned ? {16'h0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
            default: data_c = raw;
        endcase
    end

endmodule

// File: rtl/d_mem_lsu.sv
// Data-memory load/store unit: one request at a time, misaligned accesses split in two.
// Splitting is built only with D_MEM_LSU_MISALIGN_SPLIT_EN; otherwise crossing accesses error out.
module d_mem_lsu
    import d_mem_pkg::*;
#(
    parameter int unsigned ADRS_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADRS_WIDTH-1:0] req_adrs,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADRS_WIDTH-1:0] mem_adrs,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [3:0]            mem_byt_en,
    output logic                  mem_sign_ext,
    output logic [WORD_WIDTH-1:0] mem_wr_data,
    input  logic [WORD_WIDTH-1:0] mem_rd_data
);

    d_state_e state_q, state_d;
    d_size_e  req_size_c, size_q;
    logic     we_q, uns_q, err_q;
    logic     accept_c, req_bad_c;
    logic [WORD_W-1:0] ext_c;

    logic                  ready_q, ready_d, valid_q, valid_d, rerr_q, rerr_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d, wdat_q, wdat_d;
    logic [ADRS_WIDTH-1:0] madrs_q, madrs_d;
    logic                  rden_q, rden_d, wren_q, wren_d;
    logic [3:0]            ben_q, ben_d;

    assign req_size_c = d_size_e'(req_size);
    assign accept_c   = req_valid && req_ready;

`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
    localparam int unsigned WADR_W = ADRS_WIDTH - 2;

    logic [ADRS_WIDTH-1:0] adrs_q;
    logic [WORD_W-1:0]     wdata_q, part_a_q, part_a_d;
    logic [1:0]            lo_bytes;
    logic [4:0]            shamt;

    assign req_bad_c = (req_size_c == SZ_ILL);
    assign lo_bytes  = 2'(3'd4 - {1'b0, adrs_q[1:0]});
    assign shamt     = {lo_bytes, 3'b000};

    `D_MEM_DFF_RN(clk, rst_n, adrs_q,   accept_c ? req_adrs  : adrs_q,  '0)
    `D_MEM_DFF_RN(clk, rst_n, wdata_q,  accept_c ? req_wdata : wdata_q, '0)
    `D_MEM_DFF_RN(clk, rst_n, part_a_q, part_a_d, '0)
`else
    assign req_bad_c = (req_size_c == SZ_ILL) || is_crossing(req_size_c, req_adrs[1:0]);
`endif

    // Request fields held for the whole transaction
    `D_MEM_DFF_RN(clk, rst_n, we_q,   accept_c ? req_we       : we_q,   1'b0)
    `D_MEM_DFF_RN(clk, rst_n, size_q, accept_c ? req_size_c   : size_q, SZ_BYTE)
    `D_MEM_DFF_RN(clk, rst_n, uns_q,  accept_c ? req_unsigned : uns_q,  1'b0)
    `D_MEM_DFF_RN(clk, rst_n, err_q,  accept_c ? req_bad_c    : err_q,  1'b0)

    `D_MEM_DFF_RN(clk, rst_n, state_q, state_d, ST_IDLE)
    `D_MEM_DFF_RN(clk, rst_n, ready_q, ready_d, 1'b1)
    `D_MEM_DFF_RN(clk, rst_n, valid_q, valid_d, 1'b0)
    `D_MEM_DFF_RN(clk, rst_n, rerr_q,  rerr_d,  1'b0)
    `D_MEM_DFF_RN(clk, rst_n, rdata_q, rdata_d, '0)
    `D_MEM_DFF_RN(clk, rst_n, madrs_q, madrs_d, '0)
    `D_MEM_DFF_RN(clk, rst_n, rden_q,  rden_d,  1'b0)
    `D_MEM_DFF_RN(clk, rst_n, wren_q,  wren_d,  1'b0)
    `D_MEM_DFF_RN(clk, rst_n, ben_q,   ben_d,   4'b0000)
    `D_MEM_DFF_RN(clk, rst_n, wdat_q,  wdat_d,  '0)

    d_mem_ld_ext u_ld_ext (
`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
        .part_a      (part_a_q),
        .offset      (adrs_q[1:0]),
        .merge       (state_q == ST_P2),
`endif
        .rd_data     (mem_rd_data),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data_c      (ext_c)
    );

    // Next state plus the output values for the state being entered.
    // Errored requests pass through P1 with no memory access to keep the 2-cycle latency.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        valid_d = 1'b0;
        rerr_d  = 1'b0;
        rdata_d = '0;
        madrs_d = '0;
        rden_d  = 1'b0;
        wren_d  = 1'b0;
        ben_d   = 4'b0000;
        wdat_d  = '0;
`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
        part_a_d = part_a_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    state_d = ST_P1;
                    ready_d = 1'b0;
                    if (!req_bad_c) begin
                        madrs_d = req_adrs;
                        ben_d   = size_mask(req_size_c);
                        wdat_d  = req_wdata;
                        rden_d  = !req_we;
                        wren_d  = req_we;
                    end
                end
            end
            ST_P1: begin
`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
                if (!err_q && is_crossing(size_q, adrs_q[1:0])) begin
                    state_d  = ST_P2;
                    madrs_d  = {adrs_q[ADRS_WIDTH-1:2] + WADR_W'(1), 2'b00};
                    ben_d    = size_mask(size_q) >> lo_bytes;
                    wdat_d   = wdata_q >> shamt;
                    rden_d   = !we_q;
                    wren_d   = we_q;
                    part_a_d = mem_rd_data;
                end else
`endif
                begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    rerr_d  = err_q;
                    rdata_d = (we_q || err_q) ? '0 : ext_c;
                end
            end
`ifdef D_MEM_LSU_MISALIGN_SPLIT_EN
            ST_P2: begin
                state_d = ST_DONE;
                valid_d = 1'b1;
                rdata_d = we_q ? '0 : ext_c;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset masks every output in the same cycle, so a write in flight never commits
    assign req_ready    = ready_q & rst_n;
    assign rsp_valid    = valid_q & rst_n;
    assign rsp_err      = rerr_q & rst_n;
    assign rsp_rdata    = rdata_q & {WORD_W{rst_n}};
    assign mem_adrs     = madrs_q & {ADRS_WIDTH{rst_n}};
    assign mem_rden     = rden_q & rst_n;
    assign mem_wren     = wren_q & rst_n;
    assign mem_byt_en   = ben_q & {4{rst_n}};
    assign mem_wr_data  = wdat_q & {WORD_W{rst_n}};
    assign mem_sign_ext = 1'b0;

endmodule
